// File: rtl/control_multiciclo.sv
// Multicycle control FSM for an RV32I datapath: fetch, decode, execute,
// memory access and writeback, with a memory-ready handshake and a retired-instruction counter.
module control_multiciclo #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             ALUSrc,
    output logic [1:0]       ALUOp,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             PCSrc,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        ALU_WB   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        ILLEGAL  = 4'd10
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] retired_reg;
    logic             retire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= FETCH;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire)
                retired_reg <= retired_reg + CNT_W'(1);
        end
    end

    // Next-state logic; retire marks the transition that completes an instruction.
    always_comb begin
        state_next = FETCH;
        retire     = 1'b0;
        case (state_reg)
            FETCH:    state_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_R:                state_next = EXEC_R;
                    OP_I:                state_next = EXEC_I;
                    OP_LOAD, OP_STORE:   state_next = MEM_ADDR;
                    OP_BRANCH:           state_next = BRANCH;
                    default:             state_next = ILLEGAL;
                endcase
            end
            EXEC_R:   state_next = ALU_WB;
            EXEC_I:   state_next = ALU_WB;
            ALU_WB: begin
                state_next = FETCH;
                retire     = 1'b1;
            end
            MEM_ADDR: state_next = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            MEM_RD:   state_next = mem_ready ? MEM_WB : MEM_RD;
            MEM_WB: begin
                state_next = FETCH;
                retire     = 1'b1;
            end
            MEM_WR: begin
                state_next = mem_ready ? FETCH : MEM_WR;
                retire     = mem_ready;
            end
            BRANCH: begin
                state_next = FETCH;
                retire     = 1'b1;
            end
            ILLEGAL:  state_next = FETCH;
            default:  state_next = FETCH;
        endcase
    end

    // Outputs are forced low while rst_n is asserted so no write enable fires in the reset cycle.
    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = 2'b00;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        PCSrc    = 1'b0;
        illegal  = 1'b0;
        if (rst_n) begin
            case (state_reg)
                FETCH: begin
                    MemRead = 1'b1;
                    PCWrite = mem_ready;
                    IRWrite = mem_ready;
                end
                EXEC_R:   ALUOp = 2'b10;
                EXEC_I: begin
                    ALUSrc = 1'b1;
                    ALUOp  = 2'b10;
                end
                ALU_WB:   RegWrite = 1'b1;
                MEM_ADDR: ALUSrc = 1'b1;
                MEM_RD:   MemRead = 1'b1;
                MEM_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                MEM_WR:   MemWrite = 1'b1;
                BRANCH: begin
                    ALUOp   = 2'b01;
                    PCWrite = zero;
                    PCSrc   = zero;
                end
                ILLEGAL:  illegal = 1'b1;
                default: begin
                end
            endcase
        end
    end

    assign retired = retired_reg;

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo: walks each instruction class state by state
// and checks the decoded control word and retired counter against hand-computed values.
module tb_control_multiciclo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite, IRWrite, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, PCSrc, illegal;
    logic [1:0]  ALUOp;
    logic [31:0] retired;
    logic        s_pcw, s_irw, s_alusrc, s_mrd, s_mwr, s_m2r, s_rw, s_pcsrc, s_ill;
    logic [1:0]  s_aluop;
    logic [2:0]  retired_small;
    logic [10:0] outs;
    logic [31:0] instr;
    int          checks = 0;
    int          passes = 0;

    // Control word order: PCWrite IRWrite ALUSrc ALUOp[1:0] MemRead MemWrite MemtoReg RegWrite PCSrc illegal
    localparam logic [10:0] W_FETCH    = 11'b11000100000;
    localparam logic [10:0] W_FSTALL   = 11'b00000100000;
    localparam logic [10:0] W_NONE     = 11'b00000000000;
    localparam logic [10:0] W_EXEC_R   = 11'b00010000000;
    localparam logic [10:0] W_EXEC_I   = 11'b00110000000;
    localparam logic [10:0] W_ALU_WB   = 11'b00000000100;
    localparam logic [10:0] W_MEM_ADDR = 11'b00100000000;
    localparam logic [10:0] W_MEM_RD   = 11'b00000100000;
    localparam logic [10:0] W_MEM_WB   = 11'b00000001100;
    localparam logic [10:0] W_MEM_WR   = 11'b00000010000;
    localparam logic [10:0] W_BR_TAKEN = 11'b10001000010;
    localparam logic [10:0] W_BR_NOT   = 11'b00001000000;
    localparam logic [10:0] W_ILLEGAL  = 11'b00000000001;

    always #5 clk = ~clk;

    assign outs = {PCWrite, IRWrite, ALUSrc, ALUOp, MemRead, MemWrite, MemtoReg, RegWrite, PCSrc, illegal};

    control_multiciclo #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .PCSrc(PCSrc), .illegal(illegal), .retired(retired)
    );

    // Narrow counter instance shares the stimulus so the wrap boundary is reachable quickly.
    control_multiciclo #(.CNT_W(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(s_pcw), .IRWrite(s_irw), .ALUSrc(s_alusrc), .ALUOp(s_aluop),
        .MemRead(s_mrd), .MemWrite(s_mwr), .MemtoReg(s_m2r), .RegWrite(s_rw),
        .PCSrc(s_pcsrc), .illegal(s_ill), .retired(retired_small)
    );

    // Check the control word for the current state, then advance one clock.
    task automatic step(input string tag, input logic [10:0] exp);
        #1;
        checks++;
        assert (outs === exp) passes++;
        else $error("FAIL %s: outs=%b expected %b", tag, outs, exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_ret(input string tag, input logic [31:0] exp);
        #1;
        checks++;
        assert (retired === exp) passes++;
        else $error("FAIL %s: retired=%0d expected %0d", tag, retired, exp);
    endtask

    task automatic chk_small(input string tag, input logic [2:0] exp);
        #1;
        checks++;
        assert (retired_small === exp) passes++;
        else $error("FAIL %s: retired_small=%0d expected %0d", tag, retired_small, exp);
    endtask

    task automatic run_addi(input string tag);
        instr = 32'h00500093;
        mem_ready = 1'b1;
        opcode = instr[6:0];
        step({tag, "_fetch"}, W_FETCH);
        step({tag, "_decode"}, W_NONE);
        step({tag, "_exec_i"}, W_EXEC_I);
        step({tag, "_alu_wb"}, W_ALU_WB);
    endtask

    initial begin
        rst_n = 1'b0;
        opcode = 7'd0;
        zero = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        step("reset_outs", W_NONE);
        chk_ret("reset_retired", 32'd0);
        rst_n = 1'b1;

        // addi x1,x0,5
        run_addi("addi");
        chk_ret("addi_retired", 32'd1);

        // add x3,x1,x2, with one stalled fetch first
        instr = 32'h002081B3;
        opcode = instr[6:0];
        mem_ready = 1'b0;
        step("add_fetch_stall", W_FSTALL);
        mem_ready = 1'b1;
        step("add_fetch", W_FETCH);
        mem_ready = 1'b0;
        step("add_decode", W_NONE);
        step("add_exec_r", W_EXEC_R);
        chk_ret("add_before_wb", 32'd1);
        step("add_alu_wb", W_ALU_WB);
        chk_ret("add_retired", 32'd2);

        // lw x5,0(x1) with three not-ready cycles in MEM_RD
        instr = 32'h0000A283;
        opcode = instr[6:0];
        mem_ready = 1'b1;
        step("lw_fetch", W_FETCH);
        step("lw_decode", W_NONE);
        step("lw_mem_addr", W_MEM_ADDR);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_mem_rd_wait", W_MEM_RD);
        mem_ready = 1'b1;
        step("lw_mem_rd", W_MEM_RD);
        step("lw_mem_wb", W_MEM_WB);
        chk_ret("lw_retired", 32'd3);

        // sw x5,4(x1) with two not-ready cycles in MEM_WR
        instr = 32'h0050A223;
        opcode = instr[6:0];
        step("sw_fetch", W_FETCH);
        step("sw_decode", W_NONE);
        step("sw_mem_addr", W_MEM_ADDR);
        mem_ready = 1'b0;
        step("sw_mem_wr_wait", W_MEM_WR);
        chk_ret("sw_stalled", 32'd3);
        step("sw_mem_wr_wait", W_MEM_WR);
        mem_ready = 1'b1;
        step("sw_mem_wr", W_MEM_WR);
        chk_ret("sw_retired", 32'd4);

        // beq x0,x0,8 taken, then not taken
        instr = 32'h00000463;
        opcode = instr[6:0];
        zero = 1'b1;
        step("beq_t_fetch", W_FETCH);
        step("beq_t_decode", W_NONE);
        step("beq_taken", W_BR_TAKEN);
        chk_ret("beq_t_retired", 32'd5);
        zero = 1'b0;
        step("beq_n_fetch", W_FETCH);
        step("beq_n_decode", W_NONE);
        step("beq_not_taken", W_BR_NOT);
        chk_ret("beq_n_retired", 32'd6);

        // Unsupported opcode: single-cycle illegal pulse, no retire
        instr = 32'hFFFFFFFF;
        opcode = instr[6:0];
        step("ill_fetch", W_FETCH);
        step("ill_decode", W_NONE);
        step("ill_pulse", W_ILLEGAL);
        chk_ret("ill_retired", 32'd6);
        mem_ready = 1'b0;
        step("ill_back_fetch", W_FSTALL);
        chk_small("small_before_reset", 3'd6);

        // Reset while a load is waiting in MEM_RD
        instr = 32'h0000A283;
        opcode = instr[6:0];
        mem_ready = 1'b1;
        step("rst_lw_fetch", W_FETCH);
        step("rst_lw_decode", W_NONE);
        step("rst_lw_mem_addr", W_MEM_ADDR);
        mem_ready = 1'b0;
        step("rst_lw_mem_rd", W_MEM_RD);
        rst_n = 1'b0;
        step("rst_cycle_outs", W_NONE);
        rst_n = 1'b1;
        chk_ret("rst_retired", 32'd0);
        step("rst_fetch_stall", W_FSTALL);

        // Wrap of the 3-bit counter: 7, then 0, then 1
        for (int i = 0; i < 7; i++) run_addi("wrap_addi");
        chk_small("small_at_7", 3'd7);
        run_addi("wrap_addi");
        chk_small("small_wrapped", 3'd0);
        chk_ret("wide_at_8", 32'd8);
        run_addi("wrap_addi");
        chk_small("small_after_wrap", 3'd1);
        chk_ret("wide_at_9", 32'd9);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
